player_move_sequencer: RTL and testbench

Controller that sits between the raw direction inputs and the player-rectangle datapath, on the btnClk domain. It arbitrates between a human button source and an AI/demo move source, issues at most one legal direction code per cycle, and gates the datapath with playerDisable. It also runs the life/respawn sequence: filters player_dead, decrements lives, pulses a datapath reset, holds the player frozen, and ends the game at zero lives.

---
 rtl/player_move_sequencer_if.sv | 26 ++
 rtl/player_move_sequencer.sv | 174 +++++++++++++++++
 tb/tb_player_move_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/player_move_sequencer_if.sv
// Bundle of the direction/AI request inputs and the datapath-facing outputs of the
// player move sequencer. The master side drives requests; the slave side is the sequencer.
interface player_move_sequencer_if;
    logic       start;
    logic [3:0] btns_h;
    logic [3:0] ai_dir;
    logic       ai_req;
    logic       player_dead;
    logic [3:0] btns_o;
    logic       ai_grant;
    logic       playerDisable;
    logic       player_rst;
    logic [2:0] lives;
    logic       game_over;
    logic [2:0] state_o;

    modport master (
        output start, btns_h, ai_dir, ai_req, player_dead,
        input  btns_o, ai_grant, playerDisable, player_rst, lives, game_over, state_o
    );

    modport slave (
        input  start, btns_h, ai_dir, ai_req, player_dead,
        output btns_o, ai_grant, playerDisable, player_rst, lives, game_over, state_o
    );
endinterface

// File: rtl/player_move_sequencer.sv
// Player move sequencer: arbitrates human buttons against AI/demo moves, issues at most
// one one-hot direction code per cycle, and runs the death/respawn/game-over sequence.
module player_move_sequencer #(
    parameter int unsigned LIVES          = 3,
    parameter int unsigned REPEAT_DIV     = 8,
    parameter int unsigned DEAD_CYCLES    = 4,
    parameter int unsigned RESPAWN_CYCLES = 16
) (
    input  logic                    btnClk,
    input  logic                    rst,
    player_move_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StPlay     = 3'd1,
        StDying    = 3'd2,
        StRespawn  = 3'd3,
        StGameOver = 3'd4
    } state_e;

    localparam logic [15:0] RepLast  = 16'(REPEAT_DIV - 1);
    localparam logic [15:0] DeadLast = 16'(DEAD_CYCLES - 1);
    localparam logic [15:0] RespLast = 16'(RESPAWN_CYCLES - 1);
    localparam logic [2:0]  LivesInit = 3'(LIVES);

    state_e      state_q;
    logic [3:0]  prev_q;       // previous cycle's reduced human code
    logic        hum_pend_q;   // human move that lost arbitration, still owed
    logic        rr_q;         // 0: human wins next contention, 1: AI wins
    logic [15:0] rep_cnt_q;
    logic [15:0] dead_cnt_q;
    logic [15:0] resp_cnt_q;
    logic [3:0]  btns_q;
    logic        ai_grant_q;
    logic        pdis_q;
    logic        prst_q;
    logic [2:0]  lives_q;
    logic        game_over_q;

    logic [3:0] h_code;
    logic       h_change, h_repeat, hum_elig, ai_elig, contend, grant_h, grant_a, death;

    // Request qualification and round-robin arbitration for the current cycle.
    always_comb begin
        h_code = 4'd0;
        if (bus.btns_h[3])      h_code = 4'b1000;
        else if (bus.btns_h[2]) h_code = 4'b0100;
        else if (bus.btns_h[1]) h_code = 4'b0010;
        else if (bus.btns_h[0]) h_code = 4'b0001;
        h_change = (h_code != prev_q);
        h_repeat = !h_change && (rep_cnt_q == RepLast);
        hum_elig = (h_code != 4'd0) && (h_change || h_repeat || hum_pend_q);
        ai_elig  = bus.ai_req && $onehot(bus.ai_dir);
        contend  = hum_elig && ai_elig;
        grant_h  = hum_elig && (!ai_elig || !rr_q);
        grant_a  = ai_elig && (!hum_elig || rr_q);
        death    = bus.player_dead && (dead_cnt_q == DeadLast);
    end

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge btnClk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            prev_q      <= 4'd0;
            hum_pend_q  <= 1'b0;
            rr_q        <= 1'b0;
            rep_cnt_q   <= 16'd0;
            dead_cnt_q  <= 16'd0;
            resp_cnt_q  <= 16'd0;
            btns_q      <= 4'd0;
            ai_grant_q  <= 1'b0;
            pdis_q      <= 1'b1;
            prst_q      <= 1'b0;
            lives_q     <= 3'd0;
            game_over_q <= 1'b0;
        end else begin
            btns_q     <= 4'd0;
            ai_grant_q <= 1'b0;
            prst_q     <= 1'b0;
            // Tracked in every state so a press held across respawn needs a fresh change.
            prev_q     <= h_code;
            unique case (state_q)
                StIdle: begin
                    pdis_q     <= 1'b1;
                    hum_pend_q <= 1'b0;
                    rep_cnt_q  <= 16'd0;
                    dead_cnt_q <= 16'd0;
                    if (bus.start) begin
                        lives_q <= LivesInit;
                        prst_q  <= 1'b1;
                        pdis_q  <= 1'b0;
                        state_q <= StPlay;
                    end
                end
                StPlay: begin
                    if (death) begin
                        // Death overrides any grant this cycle.
                        lives_q    <= (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
                        pdis_q     <= 1'b1;
                        hum_pend_q <= 1'b0;
                        dead_cnt_q <= 16'd0;
                        rep_cnt_q  <= 16'd0;
                        state_q    <= StDying;
                    end else begin
                        pdis_q     <= 1'b0;
                        dead_cnt_q <= bus.player_dead ? dead_cnt_q + 16'd1 : 16'd0;
                        if (grant_h) btns_q <= h_code;
                        if (grant_a) begin
                            btns_q     <= bus.ai_dir;
                            ai_grant_q <= 1'b1;
                        end
                        // Pointer only moves when both sources actually competed.
                        if (contend) rr_q <= ~rr_q;
                        hum_pend_q <= hum_elig && !grant_h;
                        if (h_change || h_repeat) rep_cnt_q <= 16'd0;
                        else                      rep_cnt_q <= rep_cnt_q + 16'd1;
                    end
                end
                StDying: begin
                    pdis_q <= 1'b1;
                    if (lives_q == 3'd0) begin
                        game_over_q <= 1'b1;
                        state_q     <= StGameOver;
                    end else begin
                        prst_q     <= 1'b1;
                        resp_cnt_q <= 16'd0;
                        state_q    <= StRespawn;
                    end
                end
                StRespawn: begin
                    pdis_q <= 1'b1;
                    if (resp_cnt_q == RespLast) begin
                        resp_cnt_q <= 16'd0;
                        rep_cnt_q  <= 16'd0;
                        dead_cnt_q <= 16'd0;
                        hum_pend_q <= 1'b0;
                        pdis_q     <= 1'b0;
                        state_q    <= StPlay;
                    end else begin
                        resp_cnt_q <= resp_cnt_q + 16'd1;
                    end
                end
                StGameOver: begin
                    pdis_q <= 1'b1;
                    if (bus.start) begin
                        lives_q     <= LivesInit;
                        prst_q      <= 1'b1;
                        pdis_q      <= 1'b0;
                        game_over_q <= 1'b0;
                        rep_cnt_q   <= 16'd0;
                        dead_cnt_q  <= 16'd0;
                        hum_pend_q  <= 1'b0;
                        state_q     <= StPlay;
                    end
                end
                default: begin
                    pdis_q      <= 1'b1;
                    game_over_q <= 1'b0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    assign bus.btns_o        = btns_q;
    assign bus.ai_grant      = ai_grant_q;
    assign bus.playerDisable = pdis_q;
    assign bus.player_rst    = prst_q;
    assign bus.lives         = lives_q;
    assign bus.game_over     = game_over_q;
    assign bus.state_o       = state_q;

endmodule

// File: tb/tb_player_move_sequencer.sv
// Directed bench for player_move_sequencer with hand-computed expectations.
module tb_player_move_sequencer;

    logic btnClk = 1'b0;
    logic rst    = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    player_move_sequencer_if bus ();

    player_move_sequencer dut (
        .btnClk (btnClk),
        .rst    (rst),
        .bus    (bus.slave)
    );

    always #5 btnClk = ~btnClk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge btnClk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] st, input int max_cycles);
        int n;
        n = 0;
        while (bus.state_o !== st && n < max_cycles) begin
            step();
            n++;
        end
        chk("wait_state", 32'(bus.state_o), 32'(st));
    endtask

    // Hold player_dead for DEAD_CYCLES edges; the sequencer must land in DYING.
    task automatic die(input logic [2:0] exp_lives);
        bus.player_dead = 1'b1;
        repeat (4) step();
        bus.player_dead = 1'b0;
        chk("die_state", 32'(bus.state_o), 32'd2);
        chk("die_lives", 32'(bus.lives), 32'(exp_lives));
    endtask

    initial begin
        bit hum;
        bus.start = 0; bus.btns_h = 0; bus.ai_dir = 0; bus.ai_req = 0; bus.player_dead = 0;
        repeat (2) @(posedge btnClk);
        #1;
        chk("rst_state", 32'(bus.state_o), 32'd0);
        chk("rst_pdis", 32'(bus.playerDisable), 32'd1);
        chk("rst_lives", 32'(bus.lives), 32'd0);
        chk("rst_btns", 32'(bus.btns_o), 32'd0);
        chk("rst_prst", 32'(bus.player_rst), 32'd0);
        chk("rst_go", 32'(bus.game_over), 32'd0);
        rst = 1'b0;
        step();
        chk("idle_hold", 32'(bus.state_o), 32'd0);

        // Start the game.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("start_state", 32'(bus.state_o), 32'd1);
        chk("start_lives", 32'(bus.lives), 32'd3);
        chk("start_prst", 32'(bus.player_rst), 32'd1);
        chk("start_pdis", 32'(bus.playerDisable), 32'd0);
        step();
        chk("start_prst_pulse", 32'(bus.player_rst), 32'd0);

        // Multi-hot U+R held: U wins, moves on cycles 1, 9, 17.
        bus.btns_h = 4'b1010;
        for (int i = 1; i <= 20; i++) begin
            step();
            chk($sformatf("repeat_c%0d", i), 32'(bus.btns_o),
                (i == 1 || i == 9 || i == 17) ? 32'd8 : 32'd0);
        end
        bus.btns_h = 4'b0000;
        repeat (2) step();

        // Human D and AI L both held: human wins contentions at 1, 10, 18, AI elsewhere.
        bus.btns_h = 4'b0100;
        bus.ai_req = 1'b1;
        bus.ai_dir = 4'b0001;
        for (int i = 1; i <= 18; i++) begin
            step();
            hum = (i == 1 || i == 10 || i == 18);
            chk($sformatf("arb_btns_c%0d", i), 32'(bus.btns_o), hum ? 32'd4 : 32'd1);
            chk($sformatf("arb_grant_c%0d", i), 32'(bus.ai_grant), hum ? 32'd0 : 32'd1);
        end
        bus.btns_h = 4'b0000;
        bus.ai_dir = 4'b0011;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("ai_bad_grant", 32'(bus.ai_grant), 32'd0);
            chk("ai_bad_btns", 32'(bus.btns_o), 32'd0);
        end
        bus.ai_req = 1'b0;
        bus.ai_dir = 4'b0000;
        step();

        // Three-cycle dead glitch is filtered.
        bus.player_dead = 1'b1;
        repeat (3) step();
        bus.player_dead = 1'b0;
        step();
        chk("glitch_state", 32'(bus.state_o), 32'd1);
        chk("glitch_lives", 32'(bus.lives), 32'd3);

        // Death coinciding with a fresh press: death wins, btns_o stays 0.
        bus.player_dead = 1'b1;
        repeat (3) step();
        chk("dead_pre_state", 32'(bus.state_o), 32'd1);
        bus.btns_h = 4'b0001;
        step();
        bus.player_dead = 1'b0;
        chk("death_state", 32'(bus.state_o), 32'd2);
        chk("death_lives", 32'(bus.lives), 32'd2);
        chk("death_btns", 32'(bus.btns_o), 32'd0);
        chk("death_pdis", 32'(bus.playerDisable), 32'd1);
        step();
        chk("respawn_state", 32'(bus.state_o), 32'd3);
        chk("respawn_prst", 32'(bus.player_rst), 32'd1);
        for (int j = 1; j <= 15; j++) begin
            step();
            if (j == 1)  chk("respawn_prst_pulse", 32'(bus.player_rst), 32'd0);
            if (j == 15) chk("respawn_last", 32'(bus.state_o), 32'd3);
        end
        step();
        chk("replay_state", 32'(bus.state_o), 32'd1);
        chk("replay_pdis", 32'(bus.playerDisable), 32'd0);
        for (int j = 1; j <= 3; j++) begin
            step();
            chk("replay_no_stale_move", 32'(bus.btns_o), 32'd0);
        end
        bus.btns_h = 4'b0000;

        // Second and third deaths end the game without a player_rst.
        die(3'd1);
        wait_state(3'd1, 40);
        die(3'd0);
        step();
        chk("go_state", 32'(bus.state_o), 32'd4);
        chk("go_flag", 32'(bus.game_over), 32'd1);
        chk("go_prst", 32'(bus.player_rst), 32'd0);
        bus.player_dead = 1'b1;
        repeat (5) step();
        bus.player_dead = 1'b0;
        chk("go_ignore_dead", 32'(bus.lives), 32'd0);
        chk("go_hold", 32'(bus.state_o), 32'd4);

        // Restart from GAME_OVER.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("restart_state", 32'(bus.state_o), 32'd1);
        chk("restart_lives", 32'(bus.lives), 32'd3);
        chk("restart_prst", 32'(bus.player_rst), 32'd1);
        chk("restart_go", 32'(bus.game_over), 32'd0);

        // Asynchronous reset in the middle of RESPAWN.
        die(3'd2);
        repeat (4) step();
        chk("pre_rst_state", 32'(bus.state_o), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_state", 32'(bus.state_o), 32'd0);
        chk("async_rst_lives", 32'(bus.lives), 32'd0);
        chk("async_rst_pdis", 32'(bus.playerDisable), 32'd1);
        step();
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
